// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD accumulator datapath.
package bcd_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX  = 4'd9;
    localparam logic [DIGIT_W-1:0] BCD_CORR = 4'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder with carry in/out; purely combinational.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               cin,
    output logic [DIGIT_W-1:0] s,
    output logic               cout
);

    logic [DIGIT_W:0] raw;

    always_comb begin
        raw  = (DIGIT_W+1)'({1'b0, a}) + (DIGIT_W+1)'({1'b0, b}) + (DIGIT_W+1)'(cin);
        s    = raw[DIGIT_W-1:0];
        cout = 1'b0;
        if (raw > (DIGIT_W+1)'(BCD_MAX)) begin
            s    = raw[DIGIT_W-1:0] + BCD_CORR;
            cout = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_accumulator.sv
// BCD running-total accumulator: synchronised add/clear requests fold one
// digit into an NDIGITS-wide BCD total, one digit per clock.
module bcd_accumulator
    import bcd_pkg::*;
#(
    parameter int unsigned NDIGITS     = 2,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic [DIGIT_W-1:0]         operand_in,
    input  logic                       add_req,
    input  logic                       clr_req,
    output logic [DIGIT_W*NDIGITS-1:0] acc_bcd,
    output logic                       ovf,
    output logic                       invalid,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned ACC_W = DIGIT_W * NDIGITS;
    localparam int unsigned IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIGITS - 1);

    logic [SYNC_STAGES-1:0] add_sync;
    logic [SYNC_STAGES-1:0] clr_sync;
    logic                   add_prev;
    logic                   clr_prev;
    logic                   add_p;
    logic                   clr_p;

    state_t state;
    state_t state_next;

    logic [DIGIT_W-1:0] operand;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic [DIGIT_W-1:0] cur_digit;
    logic [DIGIT_W-1:0] addend;
    logic [DIGIT_W-1:0] sum_digit;
    logic               sum_cout;

    // Sync chains and edge references reset to "high" so a request held
    // through reset must fall and rise again before it counts as an edge.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            add_sync <= '1;
            clr_sync <= '1;
            add_prev <= 1'b1;
            clr_prev <= 1'b1;
        end else begin
            add_sync[0] <= add_req;
            clr_sync[0] <= clr_req;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                add_sync[i] <= add_sync[i-1];
                clr_sync[i] <= clr_sync[i-1];
            end
            add_prev <= add_sync[SYNC_STAGES-1];
            clr_prev <= clr_sync[SYNC_STAGES-1];
        end
    end

    assign add_p = add_sync[SYNC_STAGES-1] & ~add_prev;
    assign clr_p = clr_sync[SYNC_STAGES-1] & ~clr_prev;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (clr_p) begin
            state_next = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: if (add_p && is_bcd(operand_in)) state_next = ST_ADD;
                ST_ADD:  if (idx == LAST_IDX) state_next = ST_DONE;
                ST_DONE: state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            ST_ADD:  busy = 1'b1;
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Select the digit currently being updated.
    always_comb begin
        cur_digit = '0;
        for (int i = 0; i < int'(NDIGITS); i++) begin
            if (idx == IDX_W'(i)) cur_digit = acc_bcd[i*DIGIT_W +: DIGIT_W];
        end
        addend = (idx == '0) ? operand : '0;
    end

    bcd_digit_add u_digit_add (
        .a    (cur_digit),
        .b    (addend),
        .cin  (carry),
        .s    (sum_digit),
        .cout (sum_cout)
    );

    // Datapath registers; clear takes priority in every state.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            acc_bcd <= '0;
            ovf     <= 1'b0;
            invalid <= 1'b0;
            operand <= '0;
            idx     <= '0;
            carry   <= 1'b0;
        end else if (clr_p) begin
            acc_bcd <= '0;
            ovf     <= 1'b0;
            invalid <= 1'b0;
            idx     <= '0;
            carry   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (add_p) begin
                        if (!is_bcd(operand_in)) begin
                            invalid <= 1'b1;
                        end else begin
                            operand <= operand_in;
                            invalid <= 1'b0;
                            idx     <= '0;
                            carry   <= 1'b0;
                        end
                    end
                end
                ST_ADD: begin
                    for (int i = 0; i < int'(NDIGITS); i++) begin
                        if (idx == IDX_W'(i)) acc_bcd[i*DIGIT_W +: DIGIT_W] <= sum_digit;
                    end
                    carry <= sum_cout;
                    idx   <= idx + IDX_W'(1);
                    // Flag the wrap together with the final digit so it is
                    // visible in the same cycle as done.
                    if (idx == LAST_IDX && sum_cout) ovf <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    logic unused_width;
    assign unused_width = ^ACC_W;

endmodule
